sgninv_pipe: RTL and testbench

SGNINV_PIPE -- requirements
Module: sgninv_pipe

---
 rtl/sgninv_pipe.sv | 139 +++++++++++++
 tb/tb_sgninv_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgninv_pipe.sv
`timescale 1ns/1ps
// sgninv_pipe: pass / negate / abs / ones-complement unit followed by a
// STAGES-deep elastic register pipeline with valid/ready handshakes.
// The result and its carry/overflow flags are formed combinationally when
// a word is accepted, then carried unchanged through the stages.
// Optional build macro SGNINV_SATURATE_EN: an overflowing result (only the
// most negative operand under negate/abs) becomes 011..1 instead of
// wrapping to 100..0; o_ovf is raised in both builds.
module sgninv_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SGNINV_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    // Overflow handling: clamp to the largest positive value, or wrap to
    // the most negative value (which is what plain negation yields anyway).
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] r,
                                                    input logic             ovf);
`ifdef SGNINV_SATURATE_EN
        return ovf ? MAX_VAL : r;
`else
        return ovf ? MIN_VAL : r;
`endif
    endfunction

    logic [WIDTH:0]   neg_sum;
    logic             is_min;
    logic [WIDTH-1:0] res_d;
    logic             cout_d;
    logic             ovf_d;

    logic [WIDTH-1:0] dat_q [STAGES];
    logic [STAGES-1:0] cout_q;
    logic [STAGES-1:0] ovf_q;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] adv;
    logic              adv_chain;
    logic              in_xfer;

    // Operation select: result and flags for the word on the input port.
    always_comb begin
        neg_sum = {1'b0, ~i_data} + {{WIDTH{1'b0}}, 1'b1};
        is_min  = (i_data == MIN_VAL);
        res_d   = i_data;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        case (i_mode)
            2'b00: res_d = i_data;
            2'b01: begin
                res_d  = neg_sum[WIDTH-1:0];
                cout_d = neg_sum[WIDTH];
                ovf_d  = is_min;
            end
            2'b10: begin
                if (i_data[WIDTH-1]) begin
                    res_d  = neg_sum[WIDTH-1:0];
                    cout_d = neg_sum[WIDTH];
                end
                ovf_d = is_min;
            end
            default: res_d = ~i_data;
        endcase
        res_d = sat_result(res_d, ovf_d);
    end

    // Advance chain, walked from the output back: a stage loads when it is
    // empty or the stage after it loads (last stage: when o_ready is high).
    always_comb begin
        adv       = '0;
        adv_chain = o_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv_chain = !vld_q[k] || adv_chain;
            adv[k]    = adv_chain;
        end
    end

    assign i_ready = adv[0] && !i_flush;
    assign in_xfer = i_valid && i_ready;

    // Valid bits: flush empties every stage; otherwise bubbles and words
    // shift forward wherever a stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (i_flush) begin
            vld_q <= '0;
        end else begin
            if (adv[0]) vld_q[0] <= in_xfer;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Payload: a stage only captures a real word, so a stalled output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) dat_q[k] <= '0;
            cout_q <= '0;
            ovf_q  <= '0;
        end else begin
            if (in_xfer) begin
                dat_q[0]  <= res_d;
                cout_q[0] <= cout_d;
                ovf_q[0]  <= ovf_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k] && vld_q[k-1]) begin
                    dat_q[k]  <= dat_q[k-1];
                    cout_q[k] <= cout_q[k-1];
                    ovf_q[k]  <= ovf_q[k-1];
                end
            end
        end
    end

    assign o_valid = vld_q[STAGES-1];
    assign o_data  = dat_q[STAGES-1];
    assign o_cout  = cout_q[STAGES-1];
    assign o_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_sgninv_pipe.sv
`timescale 1ns/1ps
// Directed bench for sgninv_pipe: a WIDTH=16/STAGES=2 instance plus two
// WIDTH=8 instances (STAGES=1 and STAGES=4) for the parameter sweep.
module tb_sgninv_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush, vld, ordy;
    logic [1:0]  mode;
    logic [15:0] din;
    logic        irdy, ovld, ocout, oovf;
    logic [15:0] odat;

    logic        s_flush, s_vld, s_ordy;
    logic [1:0]  s_mode;
    logic [7:0]  s_din;
    logic        a_irdy, a_ovld, a_cout, a_ovf;
    logic [7:0]  a_dat;
    logic        b_irdy, b_ovld, b_cout, b_ovf;
    logic [7:0]  b_dat;

    int total = 0;
    int bad   = 0;

`ifdef SGNINV_SATURATE_EN
    localparam logic [15:0] SAT16 = 16'h7FFF;
    localparam logic [7:0]  SAT8  = 8'h7F;
`else
    localparam logic [15:0] SAT16 = 16'h8000;
    localparam logic [7:0]  SAT8  = 8'h80;
`endif

    sgninv_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(vld), .i_ready(irdy),
        .i_mode(mode), .i_data(din), .o_valid(ovld), .o_ready(ordy),
        .o_data(odat), .o_cout(ocout), .o_ovf(oovf));

    sgninv_pipe #(.WIDTH(8), .STAGES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_flush(s_flush), .i_valid(s_vld), .i_ready(a_irdy),
        .i_mode(s_mode), .i_data(s_din), .o_valid(a_ovld), .o_ready(s_ordy),
        .o_data(a_dat), .o_cout(a_cout), .o_ovf(a_ovf));

    sgninv_pipe #(.WIDTH(8), .STAGES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_flush(s_flush), .i_valid(s_vld), .i_ready(b_irdy),
        .i_mode(s_mode), .i_data(s_din), .o_valid(b_ovld), .o_ready(s_ordy),
        .o_data(b_dat), .o_cout(b_cout), .o_ovf(b_ovf));

    logic [15:0] rd;
    logic        rc, rv;
    int          lat;
    logic [7:0]  ad, bd;
    logic        ac, bc, av, bv;
    int          al, bl;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Send one word into the 16-bit instance, wait (bounded) for it, drain it.
    task automatic run16(input logic [1:0] m, input logic [15:0] d,
                         output logic [15:0] od, output logic oc, output logic ov,
                         output int lt);
        mode = m; din = d; vld = 1'b1; ordy = 1'b1;
        step;
        vld = 1'b0;
        lt  = 1;
        while (!ovld && lt < 20) begin
            step;
            lt++;
        end
        od = odat; oc = ocout; ov = oovf;
        step;
    endtask

    // Send one word into both 8-bit instances and record when each emits it.
    task automatic run8(input logic [1:0] m, input logic [7:0] d);
        s_mode = m; s_din = d; s_vld = 1'b1; s_ordy = 1'b1;
        step;
        s_vld = 1'b0;
        al = 0; bl = 0; ad = '0; bd = '0; ac = 0; bc = 0; av = 0; bv = 0;
        for (int e = 1; e <= 12; e++) begin
            if (a_ovld && al == 0) begin al = e; ad = a_dat; ac = a_cout; av = a_ovf; end
            if (b_ovld && bl == 0) begin bl = e; bd = b_dat; bc = b_cout; bv = b_ovf; end
            step;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 0; vld = 0; ordy = 0; mode = 0; din = 0;
        s_flush = 0; s_vld = 0; s_ordy = 0; s_mode = 0; s_din = 0;
        #12;
        total++; if (ovld !== 1'b0) begin bad++; $display("FAIL reset_ovld got=%b exp=0", ovld); end
        total++; if (odat !== 16'h0) begin bad++; $display("FAIL reset_odat got=%h exp=0000", odat); end
        total++; if (ocout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", ocout); end
        total++; if (oovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", oovf); end
        total++; if (a_ovld !== 1'b0 || b_ovld !== 1'b0) begin bad++; $display("FAIL reset_ovld8 got=%b%b exp=00", a_ovld, b_ovld); end
        @(negedge clk);
        rst_n = 1'b1;
        step;
        total++; if (irdy !== 1'b1) begin bad++; $display("FAIL reset_irdy got=%b exp=1", irdy); end
        total++; if (a_irdy !== 1'b1 || b_irdy !== 1'b1) begin bad++; $display("FAIL reset_irdy8 got=%b%b exp=11", a_irdy, b_irdy); end
    endtask

    task automatic test_negate;
        run16(2'b01, 16'h0001, rd, rc, rv, lat);
        total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL neg1_data got=%h exp=ffff", rd); end
        total++; if (rc !== 1'b0) begin bad++; $display("FAIL neg1_cout got=%b exp=0", rc); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL neg1_ovf got=%b exp=0", rv); end
        total++; if (lat != 2) begin bad++; $display("FAIL neg1_latency got=%0d exp=2", lat); end
        run16(2'b01, 16'h0000, rd, rc, rv, lat);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL neg0_data got=%h exp=0000", rd); end
        total++; if (rc !== 1'b1) begin bad++; $display("FAIL neg0_cout got=%b exp=1", rc); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL neg0_ovf got=%b exp=0", rv); end
        run16(2'b01, 16'h8000, rd, rc, rv, lat);
        total++; if (rd !== SAT16) begin bad++; $display("FAIL negmin_data got=%h exp=%h", rd, SAT16); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL negmin_ovf got=%b exp=1", rv); end
    endtask

    task automatic test_abs;
        run16(2'b10, 16'h8000, rd, rc, rv, lat);
        total++; if (rd !== SAT16) begin bad++; $display("FAIL absmin_data got=%h exp=%h", rd, SAT16); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL absmin_ovf got=%b exp=1", rv); end
        total++; if (rc !== 1'b0) begin bad++; $display("FAIL absmin_cout got=%b exp=0", rc); end
        run16(2'b10, 16'hFFFB, rd, rc, rv, lat);
        total++; if (rd !== 16'h0005) begin bad++; $display("FAIL absneg_data got=%h exp=0005", rd); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL absneg_ovf got=%b exp=0", rv); end
        run16(2'b10, 16'h0005, rd, rc, rv, lat);
        total++; if (rd !== 16'h0005) begin bad++; $display("FAIL abspos_data got=%h exp=0005", rd); end
    endtask

    task automatic test_modes;
        run16(2'b00, 16'hA5A5, rd, rc, rv, lat);
        total++; if (rd !== 16'hA5A5) begin bad++; $display("FAIL pass_data got=%h exp=a5a5", rd); end
        total++; if (rc !== 1'b0 || rv !== 1'b0) begin bad++; $display("FAIL pass_flags got=%b%b exp=00", rc, rv); end
        run16(2'b11, 16'h1234, rd, rc, rv, lat);
        total++; if (rd !== 16'hEDCB) begin bad++; $display("FAIL ones_data got=%h exp=edcb", rd); end
        total++; if (rc !== 1'b0 || rv !== 1'b0) begin bad++; $display("FAIL ones_flags got=%b%b exp=00", rc, rv); end
    endtask

    task automatic test_back_to_back;
        int idx, got;
        int ocyc [3];
        logic [15:0] odv [3];
        logic acc;
        idx = 0; got = 0;
        for (int i = 0; i < 3; i++) begin ocyc[i] = -9; odv[i] = '0; end
        ordy = 1'b1; mode = 2'b01;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (idx < 3) begin vld = 1'b1; din = 16'(3 + idx); end else vld = 1'b0;
            #1;
            if (idx < 3) begin
                total++; if (irdy !== 1'b1) begin bad++; $display("FAIL b2b_irdy cycle=%0d got=%b exp=1", c, irdy); end
            end
            acc = vld && irdy;
            if (ovld && ordy) begin odv[got] = odat; ocyc[got] = c; got++; end
            step;
            if (acc) idx++;
        end
        vld = 1'b0;
        total++; if (got != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got); end
        total++; if (odv[0] !== 16'hFFFD) begin bad++; $display("FAIL b2b_w0 got=%h exp=fffd", odv[0]); end
        total++; if (odv[1] !== 16'hFFFC) begin bad++; $display("FAIL b2b_w1 got=%h exp=fffc", odv[1]); end
        total++; if (odv[2] !== 16'hFFFB) begin bad++; $display("FAIL b2b_w2 got=%h exp=fffb", odv[2]); end
        total++; if (ocyc[0] != 2) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=2", ocyc[0]); end
        total++; if (ocyc[1] != ocyc[0] + 1 || ocyc[2] != ocyc[1] + 1) begin bad++; $display("FAIL b2b_consecutive got=%0d,%0d,%0d", ocyc[0], ocyc[1], ocyc[2]); end
    endtask

    task automatic test_stall;
        logic [15:0] w [3];
        logic [15:0] odv [3];
        logic [15:0] hold;
        logic held, acc;
        int idx, got;
        w[0] = 16'h0011; w[1] = 16'h0022; w[2] = 16'h0033;
        for (int i = 0; i < 3; i++) odv[i] = '0;
        idx = 0; got = 0; held = 1'b0; hold = '0;
        ordy = 1'b0; mode = 2'b00;
        for (int c = 0; c < 5; c++) begin
            vld = (idx < 3); din = w[idx < 3 ? idx : 2];
            #1;
            if (ovld) begin
                if (!held) begin hold = odat; held = 1'b1; end
                else begin
                    total++; if (odat !== hold) begin bad++; $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, odat, hold); end
                end
            end
            acc = vld && irdy;
            step;
            if (acc) idx++;
        end
        vld = 1'b1; din = w[idx < 3 ? idx : 2];
        #1;
        total++; if (idx != 2) begin bad++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
        total++; if (irdy !== 1'b0) begin bad++; $display("FAIL stall_irdy got=%b exp=0", irdy); end
        total++; if (ovld !== 1'b1 || odat !== 16'h0011) begin bad++; $display("FAIL stall_head got=%b/%h exp=1/0011", ovld, odat); end
        ordy = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            vld = (idx < 3); din = w[idx < 3 ? idx : 2];
            #1;
            acc = vld && irdy;
            if (ovld && ordy) begin odv[got] = odat; got++; end
            step;
            if (acc) idx++;
        end
        vld = 1'b0;
        total++; if (got != 3) begin bad++; $display("FAIL stall_count got=%0d exp=3", got); end
        total++; if (odv[0] !== 16'h0011 || odv[1] !== 16'h0022 || odv[2] !== 16'h0033) begin bad++; $display("FAIL stall_order got=%h,%h,%h exp=0011,0022,0033", odv[0], odv[1], odv[2]); end
    endtask

    task automatic test_flush;
        logic stale;
        ordy = 1'b0; mode = 2'b00;
        vld = 1'b1; din = 16'h0101; step;
        din = 16'h0202; step;
        vld = 1'b0;
        total++; if (ovld !== 1'b1) begin bad++; $display("FAIL flush_pre_ovld got=%b exp=1", ovld); end
        flush = 1'b1; vld = 1'b1; din = 16'h0303;
        #1;
        total++; if (irdy !== 1'b0) begin bad++; $display("FAIL flush_irdy got=%b exp=0", irdy); end
        step;
        flush = 1'b0; vld = 1'b0;
        total++; if (ovld !== 1'b0) begin bad++; $display("FAIL flush_ovld got=%b exp=0", ovld); end
        ordy = 1'b1; stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (ovld) stale = 1'b1;
            step;
        end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL flush_stale got=%b exp=0", stale); end
        run16(2'b11, 16'h0010, rd, rc, rv, lat);
        total++; if (rd !== 16'hFFEF) begin bad++; $display("FAIL flush_new_data got=%h exp=ffef", rd); end
        total++; if (lat != 2) begin bad++; $display("FAIL flush_new_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_midreset;
        logic stray;
        ordy = 1'b0; mode = 2'b10; din = 16'h8000; vld = 1'b1;
        step;
        mode = 2'b00; din = 16'h4444;
        step;
        vld = 1'b0;
        total++; if (ovld !== 1'b1 || oovf !== 1'b1) begin bad++; $display("FAIL mrst_pre got=%b/%b exp=1/1", ovld, oovf); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (ovld !== 1'b0) begin bad++; $display("FAIL mrst_ovld got=%b exp=0", ovld); end
        total++; if (odat !== 16'h0000) begin bad++; $display("FAIL mrst_odat got=%h exp=0000", odat); end
        total++; if (oovf !== 1'b0 || ocout !== 1'b0) begin bad++; $display("FAIL mrst_flags got=%b%b exp=00", oovf, ocout); end
        @(negedge clk);
        rst_n = 1'b1; ordy = 1'b1;
        step;
        total++; if (irdy !== 1'b1) begin bad++; $display("FAIL mrst_irdy got=%b exp=1", irdy); end
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ovld) stray = 1'b1;
            step;
        end
        total++; if (stray !== 1'b0) begin bad++; $display("FAIL mrst_partial got=%b exp=0", stray); end
    endtask

    task automatic test_sweep8;
        run8(2'b01, 8'h01);
        total++; if (ad !== 8'hFF || bd !== 8'hFF) begin bad++; $display("FAIL w8_neg1_data got=%h/%h exp=ff/ff", ad, bd); end
        total++; if (ac !== 1'b0 || bc !== 1'b0 || av !== 1'b0 || bv !== 1'b0) begin bad++; $display("FAIL w8_neg1_flags got=%b%b%b%b exp=0000", ac, bc, av, bv); end
        total++; if (al != 1) begin bad++; $display("FAIL w8_s1_latency got=%0d exp=1", al); end
        total++; if (bl != 4) begin bad++; $display("FAIL w8_s4_latency got=%0d exp=4", bl); end
        run8(2'b01, 8'h00);
        total++; if (ad !== 8'h00 || bd !== 8'h00) begin bad++; $display("FAIL w8_neg0_data got=%h/%h exp=00/00", ad, bd); end
        total++; if (ac !== 1'b1 || bc !== 1'b1) begin bad++; $display("FAIL w8_neg0_cout got=%b/%b exp=1/1", ac, bc); end
        run8(2'b10, 8'h80);
        total++; if (ad !== SAT8 || bd !== SAT8) begin bad++; $display("FAIL w8_absmin_data got=%h/%h exp=%h", ad, bd, SAT8); end
        total++; if (av !== 1'b1 || bv !== 1'b1) begin bad++; $display("FAIL w8_absmin_ovf got=%b/%b exp=1/1", av, bv); end
        run8(2'b10, 8'hFB);
        total++; if (ad !== 8'h05 || bd !== 8'h05) begin bad++; $display("FAIL w8_absneg_data got=%h/%h exp=05/05", ad, bd); end
        total++; if (av !== 1'b0 || bv !== 1'b0) begin bad++; $display("FAIL w8_absneg_ovf got=%b/%b exp=0/0", av, bv); end
    endtask

    initial begin
        test_reset;
        test_negate;
        test_abs;
        test_modes;
        test_back_to_back;
        test_stall;
        test_flush;
        test_midreset;
        test_sweep8;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
